// File: rtl/cpu16_pkg.sv
// Shared constants and types for the cpu16 fetch stage.
// NOP bubble encoding, program index range, fetch FSM states, IF/ID ops.
package cpu16_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h6F0F;
  localparam logic [3:0]  PROG_MIN  = 4'd1;
  localparam logic [3:0]  PROG_MAX  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_LOAD,
    IFID_FLUSH
  } ifid_op_e;

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold, or flush to a NOP bubble.
// Ports: clk, reset, op, instr_in, pc_in -> instr, pc, valid.
module if_id_reg
  import cpu16_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  ifid_op_e          op,
  input  logic [15:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (op)
      IFID_LOAD: begin
        instr_d = instr_in;
        pc_d    = pc_in;
        valid_d = 1'b1;
      end
      IFID_FLUSH: begin
        instr_d = NOP_INSTR;
        pc_d    = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC, program launch, run/stall/branch/halt FSM, IF/ID.
// Ports: start/prog_sel launch, stall/branch/halt control, PC out, IF/ID out.
module fetch_pc_unit
  import cpu16_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int MEM_DEPTH    = 4096,
  parameter int MAX_FETCH    = 64,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        prog_sel,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic [15:0]       M_instruction,
  output logic [ADDR_W-1:0] PCAdd_pc,
  output logic [15:0]       ID_instruction,
  output logic [ADDR_W-1:0] ID_pc,
  output logic              ID_valid,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  localparam int CNT_W = $clog2(MAX_FETCH + 1);
  localparam int DRN_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] PC_LAST =
    ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_FETCH);
  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'(DRAIN_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  ifid_op_e          ifid_op;

  logic              sel_ok;
  logic [ADDR_W-1:0] sel_ext;
  logic [ADDR_W-1:0] prog_base;
  logic [ADDR_W-1:0] pc_inc;
  logic              fetch_now;

  assign sel_ok = (prog_sel >= PROG_MIN) &&
                  (prog_sel <= PROG_MAX);
  assign sel_ext = ADDR_W'(prog_sel);
  // x*100 = x*64 + x*32 + x*4
  assign prog_base = (sel_ext << 6) +
                     (sel_ext << 5) +
                     (sel_ext << 2);
  assign pc_inc = (pc_q == PC_LAST) ? '0 :
                  pc_q + ADDR_W'(1);
  assign fetch_now = !branch_taken && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ifid_op = IFID_FLUSH;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sel_ok) begin
            pc_d    = prog_base;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          ifid_op = IFID_FLUSH;
        end else if (stall) begin
          ifid_op = IFID_HOLD;
        end else begin
          ifid_op = IFID_LOAD;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        // the current cycle's fetch/branch still completes
        if (halt_req ||
            (fetch_now && cnt_d == CNT_MAX)) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        ifid_op = IFID_FLUSH;
        if (drn_q == DRN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .op       (ifid_op),
    .instr_in (M_instruction),
    .pc_in    (pc_q),
    .instr    (ID_instruction),
    .pc       (ID_pc),
    .valid    (ID_valid)
  );

  assign PCAdd_pc = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: vector table plus corner sequences.
// A second instance with MAX_FETCH=4 covers fetch-budget exhaustion.
module tb_fetch_pc_unit;

  localparam logic [15:0] NOP = 16'h6F0F;

  logic        clk = 1'b0;
  logic        reset, start, stall, br, halt;
  logic [3:0]  sel;
  logic [15:0] tgt, m_ins;
  logic [15:0] pc, id_ins, id_pc;
  logic        id_v, busy, done, err;

  logic        r2, st2;
  logic [3:0]  sel2;
  logic        z1;
  logic [15:0] z16, m2;
  logic [15:0] pc2, id_ins2, id_pc2;
  logic        id_v2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  assign m_ins = mem(pc);
  assign m2    = mem(pc2);

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_sel(sel), .stall(stall),
    .branch_taken(br), .branch_target(tgt),
    .halt_req(halt), .M_instruction(m_ins),
    .PCAdd_pc(pc), .ID_instruction(id_ins),
    .ID_pc(id_pc), .ID_valid(id_v),
    .busy(busy), .done(done), .sel_err(err)
  );

  fetch_pc_unit #(.MAX_FETCH(4)) dut2 (
    .clk(clk), .reset(r2), .start(st2),
    .prog_sel(sel2), .stall(z1),
    .branch_taken(z1), .branch_target(z16),
    .halt_req(z1), .M_instruction(m2),
    .PCAdd_pc(pc2), .ID_instruction(id_ins2),
    .ID_pc(id_pc2), .ID_valid(id_v2),
    .busy(busy2), .done(done2), .sel_err(err2)
  );

  typedef struct {
    logic        st;
    logic [3:0]  sel;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        halt;
    logic [15:0] e_pc;
    logic [15:0] e_ins;
    logic [15:0] e_idpc;
    logic        e_v;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic add(logic s, logic [3:0] sl, logic sa,
                     logic b, logic [15:0] t, logic h,
                     logic [15:0] p, logic [15:0] ins,
                     logic [15:0] ip, logic v, logic bz,
                     logic dn, logic er);
    vec_t e;
    e.st = s; e.sel = sl; e.stall = sa; e.br = b;
    e.tgt = t; e.halt = h; e.e_pc = p; e.e_ins = ins;
    e.e_idpc = ip; e.e_v = v; e.e_busy = bz;
    e.e_done = dn; e.e_err = er;
    tbl.push_back(e);
  endtask

  // plain fetch of address a, PC afterwards is a+1
  task automatic addf(logic [15:0] a);
    add(0, 0, 0, 0, 0, 0, a + 16'd1, mem(a), a,
        1, 1, 0, 0);
  endtask

  // bubble row with no control inputs
  task automatic addb(logic [15:0] p, logic bz,
                      logic dn, logic er);
    add(0, 0, 0, 0, 0, 0, p, NOP, 0, 0, bz, dn, er);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    start = 0; sel = 0; stall = 0;
    br = 0; tgt = 0; halt = 0;
  endtask

  initial begin
    reset = 1; idle_in();
    r2 = 1; st2 = 0; sel2 = 0; z1 = 0; z16 = 0;

    // launch prog 1 and fetch 100..103, halt
    add(1, 1, 0, 0, 0, 0, 100, NOP, 0, 0, 1, 0, 0);
    addf(100); addf(101); addf(102);
    add(0, 0, 0, 0, 0, 1, 104, mem(103), 103,
        1, 1, 0, 0);
    addb(104, 1, 0, 0); addb(104, 1, 0, 0);
    addb(104, 1, 0, 0); addb(104, 0, 1, 0);
    addb(104, 0, 0, 0);
    // prog 9, stall at 905
    add(1, 9, 0, 0, 0, 0, 900, NOP, 0, 0, 1, 0, 0);
    for (int a = 900; a < 905; a++) addf(16'(a));
    add(0, 0, 1, 0, 0, 0, 905, mem(904), 904,
        1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 905, mem(904), 904,
        1, 1, 0, 0);
    addf(905);
    // branch wins over stall
    add(0, 0, 1, 1, 200, 0, 200, NOP, 0, 0, 1, 0, 0);
    for (int a = 200; a < 210; a++) addf(16'(a));
    // halt at 210: fetch completes, then drain
    add(0, 0, 0, 0, 0, 1, 211, mem(210), 210,
        1, 1, 0, 0);
    addb(211, 1, 0, 0); addb(211, 1, 0, 0);
    addb(211, 1, 0, 0); addb(211, 0, 1, 0);
    addb(211, 0, 0, 0);
    // invalid selections
    add(1, 0, 0, 0, 0, 0, 211, NOP, 0, 0, 0, 0, 1);
    addb(211, 0, 0, 0);
    add(1, 12, 0, 0, 0, 0, 211, NOP, 0, 0, 0, 0, 1);
    addb(211, 0, 0, 0);
    add(1, 10, 0, 0, 0, 0, 211, NOP, 0, 0, 0, 0, 1);
    // start while busy is ignored
    add(1, 2, 0, 0, 0, 0, 200, NOP, 0, 0, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 201, mem(200), 200,
        1, 1, 0, 0);
    // halt with branch: branch applies then drain
    add(0, 0, 0, 1, 500, 1, 500, NOP, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 500, NOP, 0, 0, 1, 0, 0);
    addb(500, 1, 0, 0); addb(500, 1, 0, 0);
    addb(500, 0, 1, 0); addb(500, 0, 0, 0);

    step(); step();
    reset = 0; r2 = 0;
    chk("rst_pc", -1, pc, 0);
    chk("rst_ins", -1, id_ins, NOP);
    chk("rst_idpc", -1, id_pc, 0);
    chk("rst_v", -1, id_v, 0);
    chk("rst_busy", -1, busy, 0);
    chk("rst_done", -1, done, 0);
    chk("rst_err", -1, err, 0);
    chk("rst2_pc", -1, pc2, 0);

    foreach (tbl[i]) begin
      start = tbl[i].st; sel = tbl[i].sel;
      stall = tbl[i].stall; br = tbl[i].br;
      tgt = tbl[i].tgt; halt = tbl[i].halt;
      step();
      chk("pc", i, pc, tbl[i].e_pc);
      chk("id_ins", i, id_ins, tbl[i].e_ins);
      chk("id_v", i, id_v, tbl[i].e_v);
      chk("busy", i, busy, tbl[i].e_busy);
      chk("done", i, done, tbl[i].e_done);
      chk("sel_err", i, err, tbl[i].e_err);
      if (tbl[i].e_v)
        chk("id_pc", i, id_pc, tbl[i].e_idpc);
    end
    idle_in();

    // reset in mid-run
    start = 1; sel = 4; step(); idle_in();
    chk("mr_launch", 0, pc, 400);
    step(); step();
    chk("mr_pc", 0, pc, 402);
    reset = 1; step(); reset = 0;
    chk("mr_pc", 1, pc, 0);
    chk("mr_ins", 1, id_ins, NOP);
    chk("mr_idpc", 1, id_pc, 0);
    chk("mr_v", 1, id_v, 0);
    chk("mr_busy", 1, busy, 0);
    chk("mr_done", 1, done, 0);
    chk("mr_err", 1, err, 0);
    step();
    chk("mr_hold", 2, pc, 0);

    // fetch budget of 4 from prog 3
    st2 = 1; sel2 = 3; step(); st2 = 0; sel2 = 0;
    chk("mf_pc", 0, pc2, 300);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mf_pc", k + 1, pc2, 16'(301 + k));
      chk("mf_ins", k + 1, id_ins2, mem(16'(300 + k)));
      chk("mf_idpc", k + 1, id_pc2, 16'(300 + k));
      chk("mf_v", k + 1, id_v2, 1);
      chk("mf_busy", k + 1, busy2, 1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mf_dpc", k, pc2, 304);
      chk("mf_dv", k, id_v2, 0);
      chk("mf_dins", k, id_ins2, NOP);
      chk("mf_dbusy", k, busy2, (k == 3) ? 0 : 1);
      chk("mf_ddone", k, done2, (k == 3) ? 1 : 0);
    end
    step();
    chk("mf_done_end", 0, done2, 0);
    chk("mf_err", 0, err2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
